stream_downsize: RTL and testbench

Width-converting valid/ready stream stage that accepts one wide word of `ratio` narrow lanes per upstream handshake and emits it as `ratio` consecutive narrow beats downstream, lane 0 (LSBs) first. It is the unpacking counterpart of the stream upsizer and sits between a wide internal datapath and a narrow egress interface. A partial final word is supported through a lane count, and packet boundaries are carried through on `last`. Sustained throughput is one narrow beat per cycle with no bubble between consecutive wide words.

---
 rtl/stream_pkg.sv | 31 +++
 rtl/stream_downsize.sv | 95 +++++++++
 tb/tb_stream_downsize.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/stream_pkg.sv
// Shared helpers for the stream width converters.
// Lane sizing and lane extraction used by the upsizer and downsizer.
package stream_pkg;

  localparam int unsigned MAX_BITS = 1024;
  localparam int unsigned MAX_LANE = 64;

  typedef enum logic {
    DS_EMPTY,
    DS_BUSY
  } ds_state_e;

  function automatic int unsigned lane_idx_w(input int unsigned ratio);
    return $clog2(ratio);
  endfunction

  // Zero headroom above the word keeps the top lane's select in range.
  function automatic logic [MAX_LANE-1:0] get_lane(
    input logic [MAX_BITS-1:0] word,
    input int unsigned         idx,
    input int unsigned         w
  );
    logic [MAX_BITS+MAX_LANE-1:0] ext;
    logic [MAX_LANE-1:0]          mask;
    ext  = {{MAX_LANE{1'b0}}, word};
    mask = (w >= MAX_LANE) ? '1
         : ((MAX_LANE'(1) << w) - MAX_LANE'(1));
    return ext[idx*w +: MAX_LANE] & mask;
  endfunction

endpackage

// File: rtl/stream_downsize.sv
// Wide-to-narrow stream stage: one wide word becomes up to ratio
// narrow beats, lane 0 first, with no bubble between words.
module stream_downsize
  import stream_pkg::*;
#(
  parameter int unsigned width = 8,
  parameter int unsigned ratio = 4,
  localparam int unsigned IW   = lane_idx_w(ratio)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   up_valid,
  output logic                   up_ready,
  input  logic [width*ratio-1:0] up_data,
  input  logic [IW-1:0]          up_lanes,
  input  logic                   up_last,
  output logic                   down_valid,
  input  logic                   down_ready,
  output logic [width-1:0]       down_data,
  output logic                   down_last
);

  ds_state_e              state_q, state_d;
  logic [width*ratio-1:0] data_q, data_d;
  logic [IW-1:0]          lanes_q, lanes_d;
  logic                   last_q, last_d;
  logic [IW-1:0]          idx_q, idx_d;

  logic full;
  logic final_beat;
  logic up_hs;
  logic down_hs;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= DS_EMPTY;
      data_q  <= '0;
      lanes_q <= '0;
      last_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      lanes_q <= lanes_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    lanes_d    = lanes_q;
    last_d     = last_q;
    idx_d      = idx_q;
    full       = (state_q == DS_BUSY);
    final_beat = (idx_q == lanes_q);
    // Reload on the final beat keeps the narrow side busy every cycle.
    up_ready   = rst & (~full | (down_ready & final_beat));
    up_hs      = up_valid & up_ready;
    down_hs    = full & down_ready;
    down_valid = full;
    down_last  = full & last_q & final_beat;
    down_data  = width'(get_lane(MAX_BITS'(data_q),
                                 32'(idx_q), width));

    unique case (state_q)
      DS_EMPTY: begin
        if (up_hs) begin
          data_d  = up_data;
          lanes_d = up_lanes;
          last_d  = up_last;
          idx_d   = '0;
          state_d = DS_BUSY;
        end
      end
      DS_BUSY: begin
        if (down_hs) begin
          if (!final_beat) begin
            idx_d = idx_q + IW'(1);
          end else if (up_hs) begin
            data_d  = up_data;
            lanes_d = up_lanes;
            last_d  = up_last;
            idx_d   = '0;
          end else begin
            state_d = DS_EMPTY;
          end
        end
      end
      default: state_d = DS_EMPTY;
    endcase
  end

endmodule

// File: tb/tb_stream_downsize.sv
// Scoreboard bench for stream_downsize (width 8, ratio 4):
// directed cases followed by random words under random backpressure.
module tb_stream_downsize;

  localparam int W = 8;
  localparam int R = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          up_valid = 1'b0;
  logic          up_ready;
  logic [W*R-1:0] up_data = '0;
  logic [1:0]    up_lanes = '0;
  logic          up_last = 1'b0;
  logic          down_valid;
  logic          down_ready = 1'b1;
  logic [W-1:0]  down_data;
  logic          down_last;

  stream_downsize #(.width(W), .ratio(R)) dut (
    .clk       (clk),
    .rst       (rst),
    .up_valid  (up_valid),
    .up_ready  (up_ready),
    .up_data   (up_data),
    .up_lanes  (up_lanes),
    .up_last   (up_last),
    .down_valid(down_valid),
    .down_ready(down_ready),
    .down_data (down_data),
    .down_last (down_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } beat_t;

  beat_t q[$];
  int    passed = 0;
  int    total  = 0;
  bit    rand_mode = 1'b0;
  bit    done = 1'b0;
  logic [7:0] hs_data;
  bit    prev_stall = 1'b0;
  logic [7:0] prev_data;
  logic  prev_last;

  function automatic void check(string name, logic [31:0] got,
                                logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endfunction

  // Reference: a word expands into lanes 0..lanes, last on the top one.
  task automatic push_word(logic [31:0] d, int lanes, bit last);
    for (int i = 0; i <= lanes; i++) begin
      beat_t b;
      b.data = 8'((d >> (8 * i)) & 32'hFF);
      b.last = last && (i == lanes);
      q.push_back(b);
    end
  endtask

  task automatic send_word(logic [31:0] d, int lanes, bit last);
    int n = 0;
    up_valid = 1'b1;
    up_data  = d;
    up_lanes = 2'(lanes);
    up_last  = last;
    forever begin
      @(negedge clk);
      if (up_ready) begin
        hs_data = down_data;
        push_word(d, lanes, last);
        @(posedge clk);
        #1;
        break;
      end
      n++;
      if (n > 500) begin
        check("send_timeout", 0, 1);
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(output int n);
    n = 0;
    while (q.size() > 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    if (q.size() > 0) check("drain_timeout", q.size(), 0);
    #1;
  endtask

  initial begin
    while (!done) begin
      @(posedge clk);
      #1;
      down_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  always @(negedge clk) begin
    if (up_valid) assert (up_lanes < 2'(R - 1) + 2'd1 || R == 4);
    if (!rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 32'(down_valid), 1);
        check("stall_data", 32'(down_data), 32'(prev_data));
        check("stall_last", 32'(down_last), 32'(prev_last));
      end
      if (down_valid && down_ready) begin
        if (q.size() == 0) begin
          check("unexpected_beat", 32'(down_data), 32'hDEAD);
        end else begin
          beat_t e;
          e = q.pop_front();
          check("beat_data", 32'(down_data), 32'(e.data));
          check("beat_last", 32'(down_last), 32'(e.last));
        end
      end
      prev_stall = down_valid && !down_ready;
      prev_data  = down_data;
      prev_last  = down_last;
    end
  end

  initial begin
    int n;
    // Reset held with up_valid asserted.
    rst = 1'b0;
    up_valid = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rst_up_ready", 32'(up_ready), 0);
      check("rst_down_valid", 32'(down_valid), 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    up_valid = 1'b0;
    @(negedge clk);
    check("rel_up_ready", 32'(up_ready), 1);
    check("rel_down_valid", 32'(down_valid), 0);
    @(posedge clk);
    #1;

    // Full word, downstream always ready.
    send_word(32'h44332211, 3, 1'b1);
    up_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("full_up_ready", 32'(up_ready), (k == 4) ? 1 : 0);
      @(posedge clk);
    end
    #1;
    check("full_drained", q.size(), 0);

    // Back-to-back words with no idle cycle.
    send_word(32'h44332211, 3, 1'b0);
    send_word(32'h88776655, 3, 1'b1);
    up_valid = 1'b0;
    check("b2b_accept_lane", 32'(hs_data), 32'h44);
    drain(n);
    check("b2b_tail_cycles", n, 4);

    // Partial word: only two lanes.
    send_word(32'hDDCCBBAA, 1, 1'b1);
    up_valid = 1'b0;
    drain(n);
    check("part_cycles", n, 2);
    repeat (3) begin
      @(negedge clk);
      check("part_idle", 32'(down_valid), 0);
    end
    @(posedge clk);
    #1;

    // Reset after two lanes have left.
    send_word(32'h44332211, 3, 1'b0);
    up_valid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check("mid_pending", q.size(), 2);
    rst = 1'b0;
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("mid_down_valid", 32'(down_valid), 0);
    check("mid_down_last", 32'(down_last), 0);
    check("mid_down_data", 32'(down_data), 0);
    @(posedge clk);
    #1;
    send_word(32'h00CC00EE, 2, 1'b1);
    up_valid = 1'b0;
    drain(n);
    check("mid_next_cycles", n, 3);

    // Random words under random backpressure.
    rand_mode = 1'b1;
    for (int i = 0; i < 100; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        up_valid = 1'b0;
        repeat (gap) begin
          @(posedge clk);
          #1;
        end
      end
      send_word($urandom, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
    up_valid = 1'b0;
    drain(n);
    check("rand_drained", q.size(), 0);
    rand_mode = 1'b0;
    repeat (3) @(posedge clk);
    done = 1'b1;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
